dmem_mmio: RTL and testbench
============================

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit RAM words; power of two, 4..1024.
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_FF00, base byte address of the 16-byte register window.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memwrite  input  1  store strobe from processor; write occurs at the rising edge while high.
REQ-006 aluout  input  32  byte address of access; bits [1:0] ignored (word access only).
REQ-007 writedata  input  32  store data.
REQ-008 readdata  output  32  load data, combinational from aluout and current state.
REQ-009 gpio_out  output  32  current GPIO_OUT register value.
REQ-010 irq  output  1  interrupt request, = MATCH & IRQ_EN, combinational from registers.

Function
REQ-011 Address map: RAM at 0 .. 4*DEPTH_WORDS-1, word index aluout[log2(DEPTH_WORDS)+1:2]; registers at MMIO_BASE+0x0 GPIO_OUT, +0x4 TIMER_COUNT, +0x8 TIMER_CMP, +0xC CTRL_STATUS.
REQ-012 Any other address is unmapped: read returns 32'h0; a write changes nothing except setting sticky BADADDR.
REQ-013 Reads are zero-latency: readdata reflects register/RAM contents before the current edge, so a same-cycle write is not visible until the next cycle.
REQ-014 readdata is driven for every aluout value regardless of memwrite.
REQ-015 GPIO_OUT: read/write, full 32 bits.
REQ-016 TIMER_COUNT: when CTRL_STATUS.EN=1, increments by 1 each cycle, wrapping 32'hFFFF_FFFF -> 0; holds when EN=0.
REQ-017 A write to TIMER_COUNT loads writedata and takes priority over the increment in that cycle.
REQ-018 TIMER_CMP: read/write, full 32 bits.
REQ-019 CTRL_STATUS bits: [0] EN rw, [1] IRQ_EN rw, [8] MATCH sticky W1C, [9] BADADDR sticky W1C; all other bits read 0, writes ignored.
REQ-020 MATCH sets at the edge ending any cycle in which EN=1 and the pre-edge TIMER_COUNT equals TIMER_CMP.
REQ-021 A write of 1 to bit 8/9 clears MATCH/BADADDR; if a set condition and a clear occur in the same cycle, set wins.
REQ-022 A single CTRL_STATUS write updates EN, IRQ_EN and W1C clears atomically at the same edge.
REQ-023 irq rises the cycle after MATCH sets (with IRQ_EN=1) and stays high until MATCH is cleared or IRQ_EN is written 0.

Reset
REQ-024 While reset is high at an edge: GPIO_OUT=0, TIMER_COUNT=0, TIMER_CMP=32'hFFFF_FFFF, CTRL_STATUS=0; hence gpio_out=0 and irq=0 the following cycle.
REQ-025 Reset overrides any simultaneous memwrite to registers; RAM contents are not reset and a RAM write during reset is discarded.
REQ-026 Reset asserted mid-count stops and zeroes the timer on that edge; counting resumes only after software sets EN.

Structure
REQ-027 Register offsets, CTRL_STATUS bit positions and the TIMER_CMP reset value are constants in shared package dmem_mmio_pkg.
REQ-028 Timer (count, compare, MATCH) is sub-module dmem_timer; RAM array, address decode and readdata mux stay in dmem_mmio.
REQ-029 RAM is a plain register array with one synchronous write port and one asynchronous read port.

Verification
REQ-030 RAM: write 0xDEADBEEF to 0x10, read 0x10 next cycle -> 0xDEADBEEF; read 0x13 -> same (low bits ignored); same-cycle read during write -> old value.
REQ-031 Timer: CMP=5, CTRL=0x3 at cycle 0 -> COUNT reads 0,1,2..; MATCH reads 1 and irq=1 one cycle after COUNT=5; COUNT continues 6,7.
REQ-032 W1C: with MATCH set, write CTRL=0x103 -> MATCH=0, irq=0 next cycle, EN/IRQ_EN kept; clear coinciding with count==CMP -> MATCH remains 1.
REQ-033 Wrap/priority: write COUNT=0xFFFF_FFFE with EN=1 -> reads 0xFFFF_FFFF then 0x0; write COUNT=0x100 while enabled -> next read 0x100, not 0x101.
REQ-034 Unmapped: write to MMIO_BASE+0x10 and to 4*DEPTH_WORDS -> reads 0, BADADDR=1, RAM and registers unchanged.
REQ-035 Reset mid-run: assert reset with COUNT=0x40, GPIO=0xA5 -> next cycle COUNT=0, GPIO=0, CMP=0xFFFF_FFFF, irq=0, timer halted.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared constants and types for the data memory with memory-mapped timer/GPIO window.
// Register offsets, control bit positions and reset values live here so RTL and software agree.
package dmem_mmio_pkg;

    localparam int unsigned DATA_W = 32;

    // Byte offsets inside the 16-byte register window
    localparam logic [3:0] OFF_GPIO_OUT    = 4'h0;
    localparam logic [3:0] OFF_TIMER_COUNT = 4'h4;
    localparam logic [3:0] OFF_TIMER_CMP   = 4'h8;
    localparam logic [3:0] OFF_CTRL_STATUS = 4'hC;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned CTRL_MATCH_BIT   = 8;
    localparam int unsigned CTRL_BADADDR_BIT = 9;

    localparam logic [DATA_W-1:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

    typedef struct packed {
        logic badaddr;
        logic match;
        logic irq_en;
        logic en;
    } ctrl_t;

    // Assemble the CTRL_STATUS read view; unimplemented bits read as zero.
    function automatic logic [DATA_W-1:0] pack_ctrl(input ctrl_t c);
        logic [DATA_W-1:0] r;
        r                   = '0;
        r[CTRL_EN_BIT]      = c.en;
        r[CTRL_IRQ_EN_BIT]  = c.irq_en;
        r[CTRL_MATCH_BIT]   = c.match;
        r[CTRL_BADADDR_BIT] = c.badaddr;
        return r;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running 32-bit timer with compare register and sticky MATCH flag.
// Software writes to COUNT take priority over the increment; MATCH set beats a same-cycle clear.
module dmem_timer
    import dmem_mmio_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              count_we,
    input  logic              cmp_we,
    input  logic              match_clr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] cmp,
    output logic              match
);

    logic match_set;

    // Compare uses pre-edge count and enable
    assign match_set = en & (count == cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            cmp   <= TIMER_CMP_RST;
            match <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
            end else if (en) begin
                count <= count + DATA_W'(1);
            end
            if (cmp_we) begin
                cmp <= wdata;
            end
            match <= match_set | (match & ~match_clr);
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Word-addressed data RAM plus a 16-byte register window (GPIO, timer, control/status).
// Reads are combinational from pre-edge state; writes land on the rising edge.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 64,
    parameter logic [DATA_W-1:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] gpio_out,
    output logic              irq
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    region_e           region;
    logic [AW-1:0]     ram_idx;
    logic [3:0]        reg_off;
    logic              gpio_we;
    logic              count_we;
    logic              cmp_we;
    logic              ctrl_we;
    logic              bad_set;
    logic              match_clr;
    logic              bad_clr;

    logic [DATA_W-1:0] gpio_q;
    logic              en_q;
    logic              irq_en_q;
    logic              bad_q;
    logic [DATA_W-1:0] timer_count;
    logic [DATA_W-1:0] timer_cmp;
    logic              timer_match;
    ctrl_t             ctrl_view;

    // Byte-lane bits are never used: all accesses are whole words
    logic unused_addr_bits;
    assign unused_addr_bits = ^aluout[1:0];

    assign ram_idx = aluout[AW+1:2];
    assign reg_off = {aluout[3:2], 2'b00};

    // RAM wins if a non-default base were ever placed over it
    always_comb begin
        region = REGION_NONE;
        if (aluout[DATA_W-1:AW+2] == '0) begin
            region = REGION_RAM;
        end else if (aluout[DATA_W-1:4] == MMIO_BASE[DATA_W-1:4]) begin
            region = REGION_MMIO;
        end
    end

    always_comb begin
        gpio_we  = 1'b0;
        count_we = 1'b0;
        cmp_we   = 1'b0;
        ctrl_we  = 1'b0;
        bad_set  = 1'b0;
        if (memwrite) begin
            if (region == REGION_MMIO) begin
                gpio_we  = (reg_off == OFF_GPIO_OUT);
                count_we = (reg_off == OFF_TIMER_COUNT);
                cmp_we   = (reg_off == OFF_TIMER_CMP);
                ctrl_we  = (reg_off == OFF_CTRL_STATUS);
            end else if (region == REGION_NONE) begin
                bad_set  = 1'b1;
            end
        end
    end

    assign match_clr = ctrl_we & writedata[CTRL_MATCH_BIT];
    assign bad_clr   = ctrl_we & writedata[CTRL_BADADDR_BIT];

    // RAM: one synchronous write port, contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && memwrite && (region == REGION_RAM)) begin
            mem[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q   <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            if (gpio_we) begin
                gpio_q <= writedata;
            end
            if (ctrl_we) begin
                en_q     <= writedata[CTRL_EN_BIT];
                irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
            end
            bad_q <= bad_set | (bad_q & ~bad_clr);
        end
    end

    dmem_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .en        (en_q),
        .count_we  (count_we),
        .cmp_we    (cmp_we),
        .match_clr (match_clr),
        .wdata     (writedata),
        .count     (timer_count),
        .cmp       (timer_cmp),
        .match     (timer_match)
    );

    always_comb begin
        ctrl_view.badaddr = bad_q;
        ctrl_view.match   = timer_match;
        ctrl_view.irq_en  = irq_en_q;
        ctrl_view.en      = en_q;
    end

    always_comb begin
        readdata = '0;
        unique case (region)
            REGION_RAM: readdata = mem[ram_idx];
            REGION_MMIO: begin
                unique case (reg_off)
                    OFF_GPIO_OUT:    readdata = gpio_q;
                    OFF_TIMER_COUNT: readdata = timer_count;
                    OFF_TIMER_CMP:   readdata = timer_cmp;
                    OFF_CTRL_STATUS: readdata = pack_ctrl(ctrl_view);
                    default:         readdata = '0;
                endcase
            end
            default: readdata = '0;
        endcase
    end

    assign gpio_out = gpio_q;
    assign irq      = timer_match & irq_en_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus random traffic against a
// behavioural model of the memory map, timer and control/status rules.
module tb_dmem_mmio;

    localparam int unsigned   DEPTH  = 64;
    localparam logic [31:0]   BASE   = 32'hFFFF_FF00;
    localparam logic [31:0]   A_GPIO = BASE + 32'h0;
    localparam logic [31:0]   A_CNT  = BASE + 32'h4;
    localparam logic [31:0]   A_CMP  = BASE + 32'h8;
    localparam logic [31:0]   A_CTRL = BASE + 32'hC;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] gpio_out;
    logic        irq;

    int nchecks;
    int nerr;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_gpio, m_count, m_cmp;
    bit          m_en, m_irqen, m_match, m_bad;

    dmem_mmio #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return (a & ~32'hF) == BASE;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (is_ram(a)) return m_mem[int'(a >> 2)];
        if (is_mmio(a)) begin
            case (int'((a >> 2) & 32'd3))
                0: return m_gpio;
                1: return m_count;
                2: return m_cmp;
                default: return {22'd0, m_bad, m_match, 6'd0, m_irqen, m_en};
            endcase
        end
        return 32'h0;
    endfunction

    // Apply one rising edge to the model using only pre-edge values
    task automatic m_step(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit          mset, mclr, bclr;
        logic [31:0] ncount;
        if (rst) begin
            m_gpio = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
            m_en = 0; m_irqen = 0; m_match = 0; m_bad = 0;
            return;
        end
        mset   = m_en && (m_count == m_cmp);
        ncount = m_en ? m_count + 32'd1 : m_count;
        mclr   = 0;
        bclr   = 0;
        if (we) begin
            if (is_ram(a)) begin
                m_mem[int'(a >> 2)]   = d;
                m_known[int'(a >> 2)] = 1;
            end else if (is_mmio(a)) begin
                case (int'((a >> 2) & 32'd3))
                    0: m_gpio = d;
                    1: ncount = d;
                    2: m_cmp  = d;
                    default: begin
                        m_en = d[0]; m_irqen = d[1]; mclr = d[8]; bclr = d[9];
                    end
                endcase
            end
        end
        m_count = ncount;
        m_match = mset | (m_match & !mclr);
        m_bad   = (we && !is_ram(a) && !is_mmio(a)) | (m_bad & !bclr);
    endtask

    task automatic cycle(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
        bit known;
        @(negedge clk);
        reset = rst; memwrite = we; aluout = a; writedata = d;
        #1;
        rd    = readdata;
        known = is_ram(a) ? m_known[int'(a >> 2) & (DEPTH - 1)] : 1'b1;
        if (known) chk("readdata", readdata, m_read(a));
        chk("irq", {31'd0, irq}, {31'd0, m_match & m_irqen});
        chk("gpio_out", gpio_out, m_gpio);
        @(posedge clk);
        m_step(rst, we, a, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] junk;
        cycle(0, 1, a, d, junk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        cycle(0, 0, a, 32'h0, r);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a, d;
        bit          we, rst;
        int          sel;

        nchecks = 0;
        nerr    = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        reset = 1; memwrite = 0; aluout = 0; writedata = 0;
        repeat (2) @(posedge clk);
        m_step(1, 0, 0, 0);

        // Reset state
        rd(A_GPIO, r); chk("rst_gpio", r, 32'h0);
        rd(A_CNT, r);  chk("rst_count", r, 32'h0);
        rd(A_CMP, r);  chk("rst_cmp", r, 32'hFFFF_FFFF);
        rd(A_CTRL, r); chk("rst_ctrl", r, 32'h0);

        for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom);

        // RAM write/read, low address bits ignored, read-during-write sees old data
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, r); chk("ram_rd", r, 32'hDEAD_BEEF);
        rd(32'h13, r); chk("ram_rd_lowbits", r, 32'hDEAD_BEEF);
        cycle(0, 1, 32'h10, 32'h1234_5678, r); chk("ram_rdw_old", r, 32'hDEAD_BEEF);
        rd(32'h10, r); chk("ram_rd_new", r, 32'h1234_5678);

        // Timer counts from 0 and raises MATCH/irq after COUNT==CMP
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 8; i++) begin
            rd(A_CNT, r); chk("count_seq", r, 32'(i));
        end
        rd(A_CTRL, r); chk("ctrl_match", r, 32'h103);
        chk("irq_high", {31'd0, irq}, 32'd1);

        // W1C clear keeps EN/IRQ_EN; set beats clear in the same cycle
        wr(A_CTRL, 32'h103);
        rd(A_CTRL, r); chk("w1c_clear", r, 32'h003);
        chk("irq_low", {31'd0, irq}, 32'd0);
        wr(A_CNT, 32'd4);
        rd(A_CTRL, r); chk("ctrl_pre", r, 32'h003);
        wr(A_CTRL, 32'h103);
        rd(A_CTRL, r); chk("set_beats_clr", r, 32'h103);

        // Wraparound and write priority over increment
        wr(A_CNT, 32'hFFFF_FFFE);
        rd(A_CNT, r); chk("wrap0", r, 32'hFFFF_FFFE);
        rd(A_CNT, r); chk("wrap1", r, 32'hFFFF_FFFF);
        rd(A_CNT, r); chk("wrap2", r, 32'h0);
        wr(A_CNT, 32'h100);
        rd(A_CNT, r); chk("count_load", r, 32'h100);

        // Unmapped accesses
        wr(BASE + 32'h10, 32'hCAFE_0001);
        wr(32'(4 * DEPTH), 32'hCAFE_0002);
        rd(BASE + 32'h10, r); chk("unmapped_mmio", r, 32'h0);
        rd(32'(4 * DEPTH), r); chk("unmapped_ram", r, 32'h0);
        rd(A_CTRL, r); chk("badaddr", {31'd0, r[9]}, 32'd1);
        rd(32'h10, r); chk("ram_intact", r, 32'h1234_5678);
        wr(A_CTRL, 32'h203);
        rd(A_CTRL, r); chk("badaddr_clr", {31'd0, r[9]}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            rst = ($urandom_range(0, 59) == 0);
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            if (sel < 4)       a = 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (sel < 8)  a = BASE + 32'($urandom_range(0, 15));
            else if (sel == 8) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 32'h1000));
            else               a = $urandom;
            if (is_mmio(a) && ((a & 32'hC) == 32'h8) && ($urandom_range(0, 1) == 1))
                d = m_count + 32'($urandom_range(0, 4));
            if (is_mmio(a) && ((a & 32'hC) == 32'hC) && ($urandom_range(0, 3) != 0))
                d[0] = 1'b1;
            cycle(rst, we, a, d, r);
        end

        // Reset in the middle of counting, with a competing register write
        wr(A_GPIO, 32'hA5);
        wr(A_CTRL, 32'h3);
        wr(A_CNT, 32'h40);
        cycle(1, 1, A_GPIO, 32'h1234_5678, r);
        rd(A_CNT, r);  chk("rst_mid_count", r, 32'h0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        rd(A_GPIO, r); chk("rst_mid_gpio", r, 32'h0);
        rd(A_CMP, r);  chk("rst_mid_cmp", r, 32'hFFFF_FFFF);
        rd(A_CNT, r);  chk("rst_mid_halt", r, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
